// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: issue strobe, latency tracking, commit and D-stage stall for the multiply/divide unit
module md_issue_ctrl #(
   parameter int MUL_LAT = 5,
   parameter int DIV_LAT = 10,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       e_md_op,
   input  logic             e_md_wr,
   input  logic             e_md_addr,
   input  logic             d_md_use,
   input  logic             flush,
   output logic             md_start,
   output logic [2:0]       md_op,
   output logic             md_we,
   output logic             md_waddr,
   output logic             busy,
   output logic             commit,
   output logic [CNT_W-1:0] cnt,
   output logic             stall,
   output logic             proto_err
);
   typedef enum logic {IDLE, BUSY} state_t;
   state_t state, state_nx;
   logic [CNT_W-1:0] cnt_nx;
   logic perr_nx;
   logic op_valid;
   assign op_valid = e_md_op inside {[3'd1:3'd4]};
   assign busy = cnt != '0;
   assign md_we = reset & e_md_wr & ~flush;
   assign md_waddr = e_md_addr;
   assign stall = d_md_use & (busy | md_start);
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt <= '0;
         proto_err <= 1'b0;
      end else begin
         state <= state_nx;
         cnt <= cnt_nx;
         proto_err <= perr_nx;
      end
   end
   always_comb begin
      state_nx = state;
      cnt_nx = cnt;
      perr_nx = proto_err;
      md_start = 1'b0;
      md_op = 3'd0;
      commit = 1'b0;
      if (state == IDLE) begin
         md_start = reset & op_valid & ~flush;
         md_op = md_start ? e_md_op : 3'd0;
         cnt_nx = !md_start ? cnt : (e_md_op <= 3'd2) ? CNT_W'(MUL_LAT) : CNT_W'(DIV_LAT);
         state_nx = md_start ? BUSY : IDLE;
      end else begin
         commit = cnt == CNT_W'(1);
         cnt_nx = busy ? cnt - CNT_W'(1) : cnt;
         state_nx = commit ? IDLE : BUSY;
         perr_nx = proto_err | op_valid;
      end
   end
endmodule

// File: doc/md_issue_ctrl.md
Name: md_issue_ctrl

Overview:
Issue and sequencing controller for the E-stage multiply/divide unit in the 5-stage MIPS pipeline. It takes the E-stage MD opcode and the mthi/mtlo write request, and qualifies both against the pipeline flush. It issues a one-cycle start to the MD datapath and tracks the operation latency with its own counter. It drives the busy, commit and D-stage stall signals the hazard unit consumes.

Parameters:
MUL_LAT, 5, cycles from issue until a mult/multu result is committed to HI/LO (legal range 1..2^CNT_W-1)
DIV_LAT, 10, cycles from issue until a div/divu result is committed (legal range 1..2^CNT_W-1)
CNT_W, 4, latency counter width

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted); clears all state immediately, independent of clk
e_md_op  input  3  E-stage opcode: 000 none, 001 multu, 010 mult, 011 divu, 100 div; 101..111 treated as none
e_md_wr  input  1  E-stage mthi/mtlo request
e_md_addr  input  1  mt target: 1 = HI, 0 = LO
d_md_use  input  1  D-stage instruction is any of mult/multu/div/divu/mfhi/mflo/mthi/mtlo
flush  input  1  pipeline flush (exception/eret); kills the E-stage instruction in the same cycle
md_start  output  1  one-cycle issue strobe to the MD datapath
md_op  output  3  opcode accompanying md_start; 000 when md_start = 0
md_we  output  1  qualified HI/LO write enable
md_waddr  output  1  e_md_addr passed through
busy  output  1  operation in flight
commit  output  1  one-cycle pulse in the final latency cycle; the datapath copies its temp result into HI/LO on this edge
cnt  output  CNT_W  remaining latency cycles (debug)
stall  output  1  stall request for the D stage
proto_err  output  1  sticky flag: an illegal issue was attempted while busy

Behaviour:
- Reset values (while reset = 0): state IDLE, cnt = 0, busy = 0, commit = 0, md_start = 0, md_op = 0, md_we = 0, proto_err = 0.
- A reset asserted mid-operation drops the operation with no commit pulse. After reset releases, the block is back in IDLE.
- issue = state IDLE & e_md_op in {001..100} & !flush. md_start = issue and is combinational in the issue cycle T.
- States:
  - IDLE -> BUSY on issue. At the T edge cnt loads MUL_LAT for 001/010 and DIV_LAT for 011/100.
  - BUSY: cnt decrements by 1 on every edge.
  - When cnt == 1: commit = 1 (combinational). On that edge cnt becomes 0 and the state returns to IDLE.
- Timing:
  - busy = (cnt != 0); it is high for exactly LAT cycles, T+1..T+LAT.
  - commit is high in cycle T+LAT.
  - A new issue is legal in cycle T+LAT+1.
- Flush:
  - flush only gates issue and md_we in the current cycle.
  - An operation already in BUSY is never cancelled by flush, because it belongs to an older instruction.
- md_we = e_md_wr & !flush. It is unaffected by busy.
- stall = d_md_use & (busy | md_start). It is combinational.
- Illegal issue: e_md_op in {001..100} while BUSY. The op is ignored, cnt is undisturbed, and proto_err is set and held until reset.
- Simultaneous e_md_op and e_md_wr in the same cycle: both are honoured. md_we has no priority interaction with issue.
- Opcodes 101..111 never issue and never set proto_err.
- cnt never wraps: decrement happens only when cnt != 0.

Test Plan:
- Reset release, then e_md_op = 010 for one cycle at T -> md_start = 1 and md_op = 010 at T; busy = 1 during T+1..T+5; commit = 1 only at T+5; busy = 0 at T+6.
- e_md_op = 100 at T with d_md_use held at 1 -> stall = 1 during T..T+10; commit at T+10; stall = 0 at T+11.
- e_md_op = 001 with flush = 1 in the same cycle -> md_start = 0, busy stays 0, cnt = 0; e_md_wr = 1 with flush = 1 -> md_we = 0.
- Issue divu, then flush = 1 at T+3 -> cnt keeps decrementing and commit still fires at T+10.
- Issue multu, then force e_md_op = 011 at T+2 -> no md_start, cnt follows the multu sequence, proto_err = 1 and holds; e_md_wr = 1 with e_md_addr = 1 at T+3 -> md_we = 1, md_waddr = 1.
- Issue div, then drive reset = 0 asynchronously at mid-cycle T+4 -> busy/cnt/commit clear immediately and no commit pulse occurs; after release, e_md_op = 010 issues normally.
